exe_mc_stage: RTL

- Execute stage that consumes the ID/EX pipeline register outputs and produces the registered EXE/MEM values.
- Single-cycle ALU ops complete in one cycle.
- MUL and DIVU run iteratively over 32 cycles. During that time the block asserts freeze so the ID/EX register and the upstream stages hold.
- While an iterative op runs, bubbles are emitted downstream.

---
 rtl/exe_mc_stage.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/exe_mc_stage.sv
// Execute stage: single-cycle ALU plus iterative MUL/DIVU, registered EXE/MEM outputs.
// Latency: 1 edge for single-cycle ops; MC_ITER+2 edges for MUL/DIVU.
// Backpressure: freeze (combinational) stalls ID/EX and upstream while an iterative op runs.
//
// Ports:
//   clk, rst (sync, active-high), flush (sync bubble insert / abort)
//   Dest, Val1, Val2, Reg2, EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN : from ID/EX register
//   ALU_result, Dest_out, Reg2_out, MEM_R_EN_out, MEM_W_EN_out, WB_EN_out : registered EXE/MEM
//   freeze : hold ID/EX and upstream; busy : iterative op in flight (BUSY or DONE)
module exe_mc_stage #(
    parameter int MC_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [4:0]  Dest,
    input  logic [31:0] Val1,
    input  logic [31:0] Val2,
    input  logic [31:0] Reg2,
    input  logic [3:0]  EXE_CMD,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic        WB_EN,
    output logic [31:0] ALU_result,
    output logic [4:0]  Dest_out,
    output logic [31:0] Reg2_out,
    output logic        MEM_R_EN_out,
    output logic        MEM_W_EN_out,
    output logic        WB_EN_out,
    output logic        freeze,
    output logic        busy
);

    localparam int CNT_W = $clog2(MC_ITER + 1);

    localparam logic [3:0] CMD_ADD  = 4'b0000;
    localparam logic [3:0] CMD_SUB  = 4'b0010;
    localparam logic [3:0] CMD_AND  = 4'b0100;
    localparam logic [3:0] CMD_OR   = 4'b0101;
    localparam logic [3:0] CMD_NOR  = 4'b0110;
    localparam logic [3:0] CMD_XOR  = 4'b0111;
    localparam logic [3:0] CMD_SLL  = 4'b1000;
    localparam logic [3:0] CMD_SRA  = 4'b1001;
    localparam logic [3:0] CMD_SRL  = 4'b1010;
    localparam logic [3:0] CMD_MUL  = 4'b1100;
    localparam logic [3:0] CMD_DIVU = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Iteration datapath, shared by MUL and DIVU:
    //   MUL : a = shifting multiplicand, b = shifting multiplier, acc = product
    //   DIVU: a = dividend shifting out / quotient shifting in, b = divisor, acc = remainder
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        acc_q, acc_d;
    logic               div_q, div_d;

    // Control captured with the iterative op, released in DONE
    logic [4:0]         hdest_q, hdest_d;
    logic [31:0]        hreg2_q, hreg2_d;
    logic               hr_q, hr_d, hw_q, hw_d, hwb_q, hwb_d;

    // Output registers
    logic [31:0]        alu_q, alu_d;
    logic [4:0]         dest_q, dest_d;
    logic [31:0]        reg2_q, reg2_d;
    logic               mr_q, mr_d, mw_q, mw_d, wb_q, wb_d;

    logic               is_mc;
    logic [31:0]        alu_comb;
    logic [32:0]        rem_sh;
    logic [32:0]        rem_sub;

    assign is_mc = (EXE_CMD == CMD_MUL) || (EXE_CMD == CMD_DIVU);

    // Freeze in BUSY lasts through the cycle flush is sampled; a flush in IDLE
    // stops the MUL/DIVU from being taken, so freeze stays low there.
    assign freeze = (state_q == S_BUSY) ||
                    ((state_q == S_IDLE) && is_mc && !flush);
    assign busy   = (state_q != S_IDLE);

    always_comb begin
        alu_comb = 32'd0;
        case (EXE_CMD)
            CMD_ADD: alu_comb = Val1 + Val2;
            CMD_SUB: alu_comb = Val1 - Val2;
            CMD_AND: alu_comb = Val1 & Val2;
            CMD_OR:  alu_comb = Val1 | Val2;
            CMD_NOR: alu_comb = ~(Val1 | Val2);
            CMD_XOR: alu_comb = Val1 ^ Val2;
            CMD_SLL: alu_comb = Val1 << Val2[4:0];
            CMD_SRA: alu_comb = 32'($signed(Val1) >>> Val2[4:0]);
            CMD_SRL: alu_comb = Val1 >> Val2[4:0];
            default: alu_comb = 32'd0;
        endcase
    end

    // Restoring division step. The remainder stays below the divisor, so the
    // shifted value fits 33 bits and bit 32 of the difference is the borrow.
    // With a zero divisor the remainder never exceeds 32 bits and every step
    // "succeeds", giving an all-ones quotient.
    assign rem_sh  = {acc_q, a_q[31]};
    assign rem_sub = rem_sh - {1'b0, b_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        div_d   = div_q;
        hdest_d = hdest_q;
        hreg2_d = hreg2_q;
        hr_d    = hr_q;
        hw_d    = hw_q;
        hwb_d   = hwb_q;
        // Bubble unless a state below publishes something
        alu_d   = 32'd0;
        dest_d  = 5'd0;
        reg2_d  = 32'd0;
        mr_d    = 1'b0;
        mw_d    = 1'b0;
        wb_d    = 1'b0;

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_mc) begin
                        state_d = S_BUSY;
                        cnt_d   = '0;
                        a_d     = Val1;
                        b_d     = Val2;
                        acc_d   = 32'd0;
                        div_d   = (EXE_CMD == CMD_DIVU);
                        hdest_d = Dest;
                        hreg2_d = Reg2;
                        hr_d    = MEM_R_EN;
                        hw_d    = MEM_W_EN;
                        hwb_d   = WB_EN;
                    end else begin
                        alu_d  = alu_comb;
                        dest_d = Dest;
                        reg2_d = Reg2;
                        mr_d   = MEM_R_EN;
                        mw_d   = MEM_W_EN;
                        wb_d   = WB_EN;
                    end
                end
                S_BUSY: begin
                    if (div_q) begin
                        if (!rem_sub[32]) begin
                            acc_d = rem_sub[31:0];
                            a_d   = {a_q[30:0], 1'b1};
                        end else begin
                            acc_d = rem_sh[31:0];
                            a_d   = {a_q[30:0], 1'b0};
                        end
                    end else begin
                        acc_d = acc_q + (b_q[0] ? a_q : 32'd0);
                        a_d   = a_q << 1;
                        b_d   = b_q >> 1;
                    end
                    if (cnt_q == CNT_W'(MC_ITER - 1)) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // ID/EX still shows the finished op; it advances on this edge.
                    state_d = S_IDLE;
                    alu_d   = div_q ? a_q : acc_q;
                    dest_d  = hdest_q;
                    reg2_d  = hreg2_q;
                    mr_d    = hr_q;
                    mw_d    = hw_q;
                    wb_d    = hwb_q;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            acc_q   <= 32'd0;
            div_q   <= 1'b0;
            hdest_q <= 5'd0;
            hreg2_q <= 32'd0;
            hr_q    <= 1'b0;
            hw_q    <= 1'b0;
            hwb_q   <= 1'b0;
            alu_q   <= 32'd0;
            dest_q  <= 5'd0;
            reg2_q  <= 32'd0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            wb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            div_q   <= div_d;
            hdest_q <= hdest_d;
            hreg2_q <= hreg2_d;
            hr_q    <= hr_d;
            hw_q    <= hw_d;
            hwb_q   <= hwb_d;
            alu_q   <= alu_d;
            dest_q  <= dest_d;
            reg2_q  <= reg2_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            wb_q    <= wb_d;
        end
    end

    assign ALU_result   = alu_q;
    assign Dest_out     = dest_q;
    assign Reg2_out     = reg2_q;
    assign MEM_R_EN_out = mr_q;
    assign MEM_W_EN_out = mw_q;
    assign WB_EN_out    = wb_q;

endmodule
